// File: rtl/iz_pkg.sv
// Shared definitions for the Izhikevich neuron parameter loader.
// Contents: frame header default, payload length, fixed-point scale used by
// the neuron datapath, regular-spiking preset values and the loader state enum.
package iz_pkg;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
    localparam int         PAYLOAD_LEN         = 8;
    localparam int         SCALE               = 64;

    // Regular-spiking preset, x64 fixed point: a=0.02, b=0.2, c=-65, d=8
    localparam logic [15:0] RS_A = 16'h0001;
    localparam logic [15:0] RS_B = 16'h000D;
    localparam logic [15:0] RS_C = 16'hEFC0;
    localparam logic [15:0] RS_D = 16'h0200;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/iz_loader_watchdog.sv
// Inter-byte timeout for the parameter loader.
// Down-counter reloaded on every clear; while run is high and no clear is
// seen it counts down, and expire fires in the cycle the counter sits at its
// terminal count of zero, i.e. after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk, reset   system clock, synchronous active-low reset
//   clear        reload the counter (a byte was transferred)
//   run          count while a frame is being received
//   expire       combinational: the idle budget is used up this cycle
module iz_loader_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int             CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= LOAD_VAL;
        end else if (clear) begin
            count <= LOAD_VAL;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = run && !clear && (count == '0);

endmodule

// File: rtl/iz_param_loader.sv
// Configuration loader for the Izhikevich neuron datapath.
// Receives framed packets (header, 8 payload bytes a_hi..d_lo, XOR checksum)
// over an 8-bit valid/ready byte stream and commits a checked frame to
// param_a..param_d in a single cycle.
// Optional macro IZ_LOADER_PRESET_EN: reset loads the regular-spiking preset
// and marks it valid instead of clearing the parameters.
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   data_in/data_valid  incoming byte stream
//   data_ready          loader accepts a byte (low only in COMMIT)
//   param_a..param_d    committed parameter set
//   params_ready        committed set valid and no frame in progress
//   busy                frame reception in progress
//   load_done           one-cycle pulse on commit
//   load_error          sticky: last frame failed checksum or timed out
//
// state  | meaning
// IDLE   | waiting for header, other bytes dropped
// RECV   | collecting 8 payload bytes into shadow registers
// CHECK  | waiting for checksum byte
// COMMIT | one cycle, shadow copied to outputs, input stalled
module iz_param_loader
    import iz_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE    = HEADER_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    localparam int            IDX_W    = $clog2(PAYLOAD_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

    loader_state_t    state;
    logic [IDX_W-1:0] byte_cnt;
    logic [7:0]       shadow [PAYLOAD_LEN];
    logic [7:0]       csum_acc;
    logic             valid_q;
    logic             xfer;
    logic             wd_run;
    logic             wd_expire;

    assign xfer         = data_valid && data_ready;
    assign wd_run       = (state == RECV) || (state == CHECK);
    assign params_ready = valid_q && !busy;

    iz_loader_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (xfer),
        .run   (wd_run),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            csum_acc   <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            data_ready <= 1'b1;
`ifdef IZ_LOADER_PRESET_EN
            param_a    <= RS_A;
            param_b    <= RS_B;
            param_c    <= RS_C;
            param_d    <= RS_D;
            valid_q    <= 1'b1;
`else
            param_a    <= '0;
            param_b    <= '0;
            param_c    <= '0;
            param_d    <= '0;
            valid_q    <= 1'b0;
`endif
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer && (data_in == HEADER_BYTE)) begin
                        state      <= RECV;
                        byte_cnt   <= '0;
                        csum_acc   <= '0;
                        busy       <= 1'b1;
                        load_error <= 1'b0;
                    end
                end
                RECV: begin
                    // header value is ordinary payload here; no resync
                    if (xfer) begin
                        shadow[byte_cnt] <= data_in;
                        csum_acc         <= csum_acc ^ data_in;
                        byte_cnt         <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_IDX) begin
                            state <= CHECK;
                        end
                    end else if (wd_expire) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_error <= 1'b1;
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (data_in == csum_acc) begin
                            state      <= COMMIT;
                            data_ready <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            load_error <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_error <= 1'b1;
                    end
                end
                COMMIT: begin
                    param_a    <= {shadow[0], shadow[1]};
                    param_b    <= {shadow[2], shadow[3]};
                    param_c    <= {shadow[4], shadow[5]};
                    param_d    <= {shadow[6], shadow[7]};
                    valid_q    <= 1'b1;
                    busy       <= 1'b0;
                    load_done  <= 1'b1;
                    data_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    data_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iz_param_loader.sv
`timescale 1ns/1ps
module tb_iz_param_loader;
    import iz_pkg::*;

    localparam int TO = 32;

`ifdef IZ_LOADER_PRESET_EN
    localparam logic [15:0] R_A = RS_A;
    localparam logic [15:0] R_B = RS_B;
    localparam logic [15:0] R_C = RS_C;
    localparam logic [15:0] R_D = RS_D;
    localparam logic        R_V = 1'b1;
`else
    localparam logic [15:0] R_A = 16'h0000;
    localparam logic [15:0] R_B = 16'h0000;
    localparam logic [15:0] R_C = 16'h0000;
    localparam logic [15:0] R_D = 16'h0000;
    localparam logic        R_V = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [15:0] param_a, param_b, param_c, param_d;
    logic        params_ready, busy, load_done, load_error;

    iz_param_loader #(
        .HEADER_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .param_a     (param_a),
        .param_b     (param_b),
        .param_c     (param_c),
        .param_d     (param_d),
        .params_ready(params_ready),
        .busy        (busy),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ok;
        logic [15:0] a, b, c, d;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;
    int          done_cnt = 0;
    int          done_mark = 0;
    logic [15:0] m_a, m_b, m_c, m_d;
    logic        m_valid;

    always @(negedge clk) if (load_done === 1'b1) done_cnt++;

    initial begin
        #2ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [63:0] p);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ p[8*i +: 8];
        return x;
    endfunction

    task automatic check_params(input string tag);
        chk16({tag, "_a"}, param_a, m_a);
        chk16({tag, "_b"}, param_b, m_b);
        chk16({tag, "_c"}, param_c, m_c);
        chk16({tag, "_d"}, param_d, m_d);
    endtask

    // returns just after the accepting rising edge
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
        while (data_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
            stalls++;
        end
        if (waited >= 16) chk1("byte_accept", data_ready, 1'b1);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] pl, input logic [7:0] cs, input bit push);
        exp_t e;
        done_mark = done_cnt;
        send_byte(8'hA5);
        chk1("hdr_busy", busy, 1'b1);
        chk1("hdr_params_ready", params_ready, 1'b0);
        chk1("hdr_err_clear", load_error, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(pl[63 - 8*i -: 8]);
        e.ok = (cs == xsum(pl));
        e.a  = pl[63:48];
        e.b  = pl[47:32];
        e.c  = pl[31:16];
        e.d  = pl[15:0];
        if (push) sb.push_back(e);
        send_byte(cs);
    endtask

    // called just after the edge that accepted the checksum (or last byte)
    task automatic check_result(input string tag);
        exp_t e;
        int   n = 0;
        if (sb.size() == 0) begin
            chki({tag, "_sb_empty"}, sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        if (e.ok) begin
            @(negedge clk);
            chk1({tag, "_commit_ready"}, data_ready, 1'b0);
            chk1({tag, "_commit_busy"}, busy, 1'b1);
            chk1({tag, "_commit_early_done"}, load_done, 1'b0);
            check_params({tag, "_commit_old"});
            @(negedge clk);
            m_a = e.a; m_b = e.b; m_c = e.c; m_d = e.d; m_valid = 1'b1;
            chk1({tag, "_done"}, load_done, 1'b1);
            check_params(tag);
            chk1({tag, "_params_ready"}, params_ready, 1'b1);
            chk1({tag, "_busy"}, busy, 1'b0);
            chk1({tag, "_err"}, load_error, 1'b0);
            chk1({tag, "_ready"}, data_ready, 1'b1);
            @(negedge clk);
            chk1({tag, "_done_pulse"}, load_done, 1'b0);
        end else begin
            do begin
                @(negedge clk);
                n++;
            end while (busy === 1'b1 && n < 4 * TO);
            chki({tag, "_abort_latency"}, n, 1);
            chk1({tag, "_busy"}, busy, 1'b0);
            chk1({tag, "_err"}, load_error, 1'b1);
            chk1({tag, "_params_ready"}, params_ready, m_valid);
            check_params(tag);
            @(negedge clk);
            chki({tag, "_no_done"}, done_cnt, done_mark);
        end
    endtask

    localparam logic [63:0] RS_FRAME = 64'h0001_000D_EFC0_0200;

    initial begin
        m_a = R_A; m_b = R_B; m_c = R_C; m_d = R_D; m_valid = R_V;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_params("rst");
        chk1("rst_params_ready", params_ready, R_V);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", load_done, 1'b0);
        chk1("rst_err", load_error, 1'b0);
        chk1("rst_ready", data_ready, 1'b1);
        reset = 1'b1;

        // bad checksum before any commit
        send_frame(RS_FRAME, 8'h22, 1'b1);
        check_result("bad_first");

        // leading junk in IDLE, then the valid frame
        send_byte(8'h3C);
        send_byte(8'h00);
        send_byte(8'hFF);
        chk1("junk_busy", busy, 1'b0);
        chk1("junk_err_sticky", load_error, 1'b1);
        chki("rs_csum_model", xsum(RS_FRAME), 8'h21);
        send_frame(RS_FRAME, 8'h21, 1'b1);
        check_result("good_rs");

        // bad checksum with a prior valid set
        send_frame(RS_FRAME, 8'h22, 1'b1);
        check_result("bad_prior");

        // timeout after header plus three payload bytes
        done_mark = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        sb.push_back('{ok: 1'b0, a: 16'h0, b: 16'h0, c: 16'h0, d: 16'h0});
        repeat (TO) @(negedge clk);
        chk1("timeout_edge_minus1_busy", busy, 1'b1);
        chk1("timeout_edge_minus1_err", load_error, 1'b0);
        check_result("timeout");

        // following valid frame clears the error on its header
        send_frame(64'h0002_0033_F380_0100, xsum(64'h0002_0033_F380_0100), 1'b1);
        check_result("after_timeout");

        // header values inside the payload, no stalls apart from COMMIT
        stalls = 0;
        send_frame(64'hA5A5_0000_0000_0000, 8'h00, 1'b1);
        chki("a5_payload_stalls", stalls, 0);
        check_result("a5_payload");

        // reset asserted while in COMMIT
        done_mark = done_cnt;
        send_frame(64'h1111_2222_3333_4444, xsum(64'h1111_2222_3333_4444), 1'b0);
        @(negedge clk);
        chk1("rc_in_commit", data_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        m_a = R_A; m_b = R_B; m_c = R_C; m_d = R_D; m_valid = R_V;
        check_params("rc");
        chk1("rc_done", load_done, 1'b0);
        chk1("rc_params_ready", params_ready, R_V);
        chk1("rc_busy", busy, 1'b0);
        chk1("rc_err", load_error, 1'b0);
        chk1("rc_ready", data_ready, 1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chki("rc_no_done", done_cnt, done_mark);
        check_params("rc_hold");

        chki("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
